axil_rd_route_tracker: RTL and testbench
========================================

# axil_rd_route_tracker

Parametrised AXI-Lite read-path decoder for the interconnect. It decodes each read address against the shared address map and records the selected slave in an in-order tracking FIFO. It then steers R-channel routing from the FIFO head, so up to DEPTH reads can be outstanding. Reads to a different slave are held back until earlier reads drain, and unmapped addresses route to a default error slave.

## Interface
- NUM_SLV, default NUMBER_SLAVE (axil_pkg): number of mapped slaves; index NUM_SLV is the default/DECERR slave
- ADDR_W, default AXI_ADDR_WIDTH (axil_pkg): address width
- DEPTH, default 4: maximum outstanding reads; power of two, 2..16
- CNT_W, default 16: width of the optional decode-miss counter
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low; clock aclk
- m_araddr  in  ADDR_W  master read address
- m_arvalid  in  1  master AR valid
- m_arready  in  1  AR ready after the interconnect mux and gating; handshake = m_arvalid && m_arready
- ar_sel  out  NUM_SLV+1  one-hot combinational decode of m_araddr
- ar_block  out  1  high = interconnect must force upstream arready low
- m_rvalid  in  1  R valid after the interconnect mux
- m_rready  in  1  master R ready
- r_sel  out  NUM_SLV+1  one-hot R routing select (FIFO head), all-zero when empty
- outstanding  out  $clog2(DEPTH)+1  in-flight read count
- miss_cnt  out  CNT_W  decode-miss count (only with the macro defined)

## Operation
- Decode:
  - ar_sel[i] = (m_araddr >= AXI_ADDR_OFFSET[i]) && (m_araddr < AXI_ADDR_OFFSET[i] + AXI_ADDR_RANGE[i]).
  - ar_sel[NUM_SLV] = no mapped hit.
  - Overlapping regions: the lowest index wins, so ar_sel stays one-hot.
  - The sum is computed at ADDR_W+1 bits, so a region ending at 2^ADDR_W decodes correctly.
- Tracking state:
  - FIFO of one-hot selects, DEPTH entries.
  - last_sel register = select of the most recently pushed entry.
- Push: on an AR handshake, ar_sel is written at the tail and last_sel <= ar_sel.
- Pop: when m_rvalid && m_rready && outstanding != 0.
- Push and pop in the same cycle: outstanding is unchanged and both pointers advance.
- ar_block = (outstanding == DEPTH) || (outstanding != 0 && ar_sel != last_sel).
- ar_block is evaluated from registered count and last_sel, so it is loop-free with respect to m_arready.
- Pop to empty in the same cycle an AR to a different slave is presented: the AR is blocked that cycle and accepted next cycle. Behaviour is conservative and required.
- Pop while outstanding == 0 (spurious rvalid): ignored; pointers and count are unchanged.
- An AR handshake while ar_block is high is an interconnect error. The tracker still pushes if not full; pushes when full are dropped.
- State machine: none beyond the FIFO. Pointers wrap modulo DEPTH; full and empty are distinguished by the count.

## Timing
- ar_sel and ar_block: combinational, zero latency.
- A pushed select appears on r_sel the cycle after the AR handshake if the FIFO was empty. Otherwise it appears when it reaches the head.
- r_sel is driven from registered storage, with no combinational path from m_rvalid or m_rready.
- Back-to-back same-slave reads are accepted every cycle until DEPTH are outstanding.
- Reset values: outstanding=0, r_sel=0, last_sel=0, pointers=0, ar_block=0, miss_cnt=0.
- Reset mid-operation flushes all entries. Any in-flight responses are the interconnect's responsibility.

## Configuration
- AXIL_RD_TRACK_MISS_CNT_EN defined:
  - miss_cnt increments on every AR handshake with ar_sel[NUM_SLV]=1.
  - It saturates at all-ones and clears only on reset.
- AXIL_RD_TRACK_MISS_CNT_EN undefined: the miss_cnt port and counter logic are absent.

## Structure
- axil_pkg holds:
  - NUMBER_SLAVE, AXI_ADDR_WIDTH, AXI_ADDR_OFFSET[], AXI_ADDR_RANGE[] (existing).
  - New constant RD_OUTSTANDING_DEPTH as the default for DEPTH.
- One sub-module: axil_sel_fifo, a generic DEPTH x WIDTH register FIFO with a count output. The decode, block logic and counter stay in the top.

## Test plan
- Single read to slave 1 (addr = AXI_ADDR_OFFSET[1]) -> ar_sel=0b0010; r_sel=0b0010 the next cycle; after the R handshake, r_sel=0 and outstanding=0.
- Four back-to-back reads to slave 0 with rready low, DEPTH=4 -> outstanding reaches 4 and ar_block=1; one R handshake -> ar_block=0 the next cycle.
- Read to slave 0 outstanding, then AR to slave 2 -> ar_block=1 until the slave-0 R handshake; the AR is accepted the following cycle and r_sel=0b0100.
- Unmapped address (above all regions) -> ar_sel=one-hot bit NUM_SLV; r_sel selects the error slave; miss_cnt=1 with the macro defined.
- Simultaneous push and pop at outstanding=2 -> outstanding stays 2 and head order is preserved; aresetn low at outstanding=3 -> all outputs return to zero the next cycle.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI-Lite interconnect address map and read-tracking defaults.
package axil_pkg;

    localparam int unsigned NUMBER_SLAVE   = 3;
    localparam int unsigned AXI_ADDR_WIDTH = 32;

    // Slave 2 ends exactly at 2^32, so its upper bound needs the extra sum bit.
    localparam logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET [NUMBER_SLAVE] =
        '{32'h0000_0000, 32'h0000_1000, 32'hF000_0000};
    localparam logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  [NUMBER_SLAVE] =
        '{32'h0000_1000, 32'h0000_1000, 32'h1000_0000};

    localparam int unsigned RD_OUTSTANDING_DEPTH = 4;

endpackage

// File: rtl/axil_rd_route_tracker_if.sv
// AR/R routing signals between the interconnect mux and the read route tracker.
interface axil_rd_route_tracker_if #(
    parameter int unsigned NUM_SLV = axil_pkg::NUMBER_SLAVE,
    parameter int unsigned ADDR_W  = axil_pkg::AXI_ADDR_WIDTH,
    parameter int unsigned DEPTH   = axil_pkg::RD_OUTSTANDING_DEPTH
);

    logic [ADDR_W-1:0]          m_araddr;
    logic                       m_arvalid;
    logic                       m_arready;
    logic [NUM_SLV:0]           ar_sel;
    logic                       ar_block;
    logic                       m_rvalid;
    logic                       m_rready;
    logic [NUM_SLV:0]           r_sel;
    logic [$clog2(DEPTH):0]     outstanding;

    modport master (
        output m_araddr, m_arvalid, m_arready, m_rvalid, m_rready,
        input  ar_sel, ar_block, r_sel, outstanding
    );

    modport slave (
        input  m_araddr, m_arvalid, m_arready, m_rvalid, m_rready,
        output ar_sel, ar_block, r_sel, outstanding
    );

endinterface

// File: rtl/axil_sel_fifo.sv
// Generic DEPTH x WIDTH register FIFO; head reads zero when empty, full pushes dropped.
module axil_sel_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != FULL_CNT);
    assign w_do_pop  = i_pop  && (r_count != '0);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = (r_count == '0) ? '0 : r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/axil_rd_route_tracker.sv
// AXI-Lite read-path decoder and in-order R routing tracker.
// Optional decode-miss counter enabled by defining AXIL_RD_TRACK_MISS_CNT_EN.
module axil_rd_route_tracker
    import axil_pkg::*;
#(
    parameter int unsigned NUM_SLV = NUMBER_SLAVE,
    parameter int unsigned ADDR_W  = AXI_ADDR_WIDTH,
    parameter int unsigned DEPTH   = RD_OUTSTANDING_DEPTH,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axil_rd_route_tracker_if.slave    bus
`ifdef AXIL_RD_TRACK_MISS_CNT_EN
    ,
    output logic [CNT_W-1:0]          miss_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_chk
        $error("axil_rd_route_tracker: illegal DEPTH or CNT_W");
    end

    logic [NUM_SLV:0] w_ar_sel;
    logic             w_hit;
    logic [ADDR_W:0]  w_addr;
    logic [ADDR_W:0]  w_lo;
    logic [ADDR_W:0]  w_hi;
    logic [NUM_SLV:0] r_last_sel;
    logic [CW-1:0]    w_count;
    logic             w_ar_hs;
    logic             w_r_hs;

    // Lowest matching index wins so overlapping regions still give a one-hot select.
    always_comb begin
        w_ar_sel = '0;
        w_hit    = 1'b0;
        w_lo     = '0;
        w_hi     = '0;
        w_addr   = {1'b0, bus.m_araddr};
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            w_lo = {1'b0, ADDR_W'(AXI_ADDR_OFFSET[i])};
            w_hi = w_lo + {1'b0, ADDR_W'(AXI_ADDR_RANGE[i])};
            if (!w_hit && (w_addr >= w_lo) && (w_addr < w_hi)) begin
                w_ar_sel[i] = 1'b1;
                w_hit       = 1'b1;
            end
        end
        w_ar_sel[NUM_SLV] = !w_hit;
    end

    assign w_ar_hs = bus.m_arvalid && bus.m_arready;
    assign w_r_hs  = bus.m_rvalid && bus.m_rready;

    axil_sel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (NUM_SLV + 1)
    ) u_sel_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_push  (w_ar_hs),
        .i_pop   (w_r_hs),
        .i_wdata (w_ar_sel),
        .o_rdata (bus.r_sel),
        .o_count (w_count)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_last_sel <= '0;
        end else if (w_ar_hs && (w_count != FULL_CNT)) begin
            r_last_sel <= w_ar_sel;
        end
    end

    // Uses only registered count/last_sel, so there is no loop through m_arready.
    assign bus.ar_block    = (w_count == FULL_CNT) ||
                             ((w_count != '0) && (w_ar_sel != r_last_sel));
    assign bus.ar_sel      = w_ar_sel;
    assign bus.outstanding = w_count;

`ifdef AXIL_RD_TRACK_MISS_CNT_EN
    logic [CNT_W-1:0] r_miss_cnt;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_miss_cnt <= '0;
        end else if (w_ar_hs && w_ar_sel[NUM_SLV] && (r_miss_cnt != '1)) begin
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
    end

    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_axil_rd_route_tracker.sv
// Self-checking bench for axil_rd_route_tracker: directed literals plus a queue-based reference model.
module tb_axil_rd_route_tracker;

    localparam int unsigned NS    = 3;
    localparam int unsigned DEPTH = 4;

    logic aclk = 1'b0;
    logic aresetn;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    always #5 aclk = ~aclk;

    axil_rd_route_tracker_if #(.NUM_SLV(NS), .ADDR_W(32), .DEPTH(DEPTH)) bus ();

`ifdef AXIL_RD_TRACK_MISS_CNT_EN
    logic [15:0] miss_cnt;
`endif

    axil_rd_route_tracker #(
        .NUM_SLV (NS),
        .ADDR_W  (32),
        .DEPTH   (DEPTH),
        .CNT_W   (16)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
`ifdef AXIL_RD_TRACK_MISS_CNT_EN
        ,
        .miss_cnt (miss_cnt)
`endif
    );

    // Reference model: queue of slave indices in issue order.
    int unsigned q[$];
    int unsigned m_last = 0;
    int unsigned m_miss = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int unsigned ref_decode(logic [31:0] a);
        longint unsigned la = longint'(a);
        for (int i = 0; i < NS; i++) begin
            longint unsigned lo = longint'(axil_pkg::AXI_ADDR_OFFSET[i]);
            longint unsigned hi = lo + longint'(axil_pkg::AXI_ADDR_RANGE[i]);
            if (la >= lo && la < hi) return i;
        end
        return NS;
    endfunction

    function automatic bit ref_block(logic [31:0] a);
        return (q.size() == DEPTH) || (q.size() != 0 && ref_decode(a) != m_last);
    endfunction

    always @(posedge aclk) begin
        int unsigned idx;
        bit hs, push, pop;
        if (!aresetn) begin
            q.delete();
            m_last = 0;
            m_miss = 0;
        end else begin
            idx  = ref_decode(bus.m_araddr);
            hs   = bus.m_arvalid && bus.m_arready;
            push = hs && (q.size() < DEPTH);
            pop  = bus.m_rvalid && bus.m_rready && (q.size() != 0);
            if (hs && idx == NS && m_miss != 32'hFFFF) m_miss++;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(idx);
                m_last = idx;
            end
        end
    end

    always @(negedge aclk) begin
        if (chk_en) begin
            chk("m_ar_sel",      32'(bus.ar_sel),      32'(4'(1) << ref_decode(bus.m_araddr)));
            chk("m_ar_block",    32'(bus.ar_block),    32'(ref_block(bus.m_araddr)));
            chk("m_r_sel",       32'(bus.r_sel),       (q.size() != 0) ? 32'(4'(1) << q[0]) : 32'h0);
            chk("m_outstanding", 32'(bus.outstanding), 32'(q.size()));
`ifdef AXIL_RD_TRACK_MISS_CNT_EN
            chk("m_miss_cnt",    32'(miss_cnt),        32'(m_miss));
`endif
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_ar(logic [31:0] a, logic v, logic rdy);
        bus.m_araddr  = a;
        bus.m_arvalid = v;
        bus.m_arready = rdy;
    endtask

    task automatic set_r(logic v, logic rdy);
        bus.m_rvalid = v;
        bus.m_rready = rdy;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned s;
        int unsigned k;
        logic [31:0] unm [4];
        unm = '{32'h0000_2000, 32'h0002_0000, 32'h8000_0000, 32'hEFFF_FFFF};
        k = $urandom_range(0, 9);
        if (k == 9) return unm[$urandom_range(0, 3)];
        s = (k < 6 && m_last < NS) ? m_last : $urandom_range(0, NS - 1);
        case ($urandom_range(0, 3))
            0:       return axil_pkg::AXI_ADDR_OFFSET[s];
            1:       return axil_pkg::AXI_ADDR_OFFSET[s] + axil_pkg::AXI_ADDR_RANGE[s] - 32'd1;
            default: return axil_pkg::AXI_ADDR_OFFSET[s] + ($urandom % axil_pkg::AXI_ADDR_RANGE[s]);
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        aresetn = 1'b0;
        set_ar(32'h0, 1'b0, 1'b0);
        set_r(1'b0, 1'b0);
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge aclk);
        chk("rst_outstanding", 32'(bus.outstanding), 32'd0);
        chk("rst_r_sel",       32'(bus.r_sel),       32'd0);
        chk("rst_ar_block",    32'(bus.ar_block),    32'd0);
        tick();
        aresetn = 1'b1;
        tick();

        // Single read to slave 1
        set_ar(32'h0000_1000, 1'b1, 1'b1);
        @(negedge aclk);
        chk("t1_ar_sel", 32'(bus.ar_sel), 32'b0010);
        chk("t1_block",  32'(bus.ar_block), 32'd0);
        tick();
        set_ar(32'h0, 1'b0, 1'b0);
        @(negedge aclk);
        chk("t1_r_sel", 32'(bus.r_sel), 32'b0010);
        chk("t1_out",   32'(bus.outstanding), 32'd1);
        set_r(1'b1, 1'b1);
        tick();
        set_r(1'b0, 1'b0);
        @(negedge aclk);
        chk("t1_r_sel_empty", 32'(bus.r_sel), 32'd0);
        chk("t1_out_empty",   32'(bus.outstanding), 32'd0);

        // Decode boundaries
        set_ar(32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge aclk);
        chk("dec_top", 32'(bus.ar_sel), 32'b0100);
        tick();
        set_ar(32'h0000_2000, 1'b0, 1'b0);
        @(negedge aclk);
        chk("dec_gap", 32'(bus.ar_sel), 32'b1000);
        tick();
        set_ar(32'h0000_0FFF, 1'b0, 1'b0);
        @(negedge aclk);
        chk("dec_s0_end", 32'(bus.ar_sel), 32'b0001);
        tick();

        // Fill to DEPTH with slave 0
        for (int i = 0; i < 4; i++) begin
            set_ar(32'h0000_0010, 1'b1, 1'b1);
            tick();
        end
        set_ar(32'h0000_0010, 1'b1, 1'b0);
        @(negedge aclk);
        chk("t2_out_full",   32'(bus.outstanding), 32'd4);
        chk("t2_block_full", 32'(bus.ar_block), 32'd1);
        set_r(1'b1, 1'b1);
        tick();
        set_r(1'b0, 1'b0);
        @(negedge aclk);
        chk("t2_block_rel", 32'(bus.ar_block), 32'd0);
        chk("t2_out_3",     32'(bus.outstanding), 32'd3);
        set_ar(32'h0, 1'b0, 1'b0);
        set_r(1'b1, 1'b1);
        repeat (3) tick();
        set_r(1'b0, 1'b0);

        // Different slave held until drain
        set_ar(32'h0000_0020, 1'b1, 1'b1);
        tick();
        set_ar(32'hF000_0000, 1'b1, 1'b0);
        @(negedge aclk);
        chk("t3_block", 32'(bus.ar_block), 32'd1);
        set_r(1'b1, 1'b1);
        tick();
        set_r(1'b0, 1'b0);
        @(negedge aclk);
        chk("t3_unblock", 32'(bus.ar_block), 32'd0);
        bus.m_arready = 1'b1;
        tick();
        set_ar(32'h0, 1'b0, 1'b0);
        @(negedge aclk);
        chk("t3_r_sel", 32'(bus.r_sel), 32'b0100);
        set_r(1'b1, 1'b1);
        tick();
        set_r(1'b0, 1'b0);

        // Unmapped address routes to the error slave
        set_ar(32'h0002_0000, 1'b1, 1'b1);
        @(negedge aclk);
        chk("t4_ar_sel", 32'(bus.ar_sel), 32'b1000);
        tick();
        set_ar(32'h0, 1'b0, 1'b0);
        @(negedge aclk);
        chk("t4_r_sel", 32'(bus.r_sel), 32'b1000);
`ifdef AXIL_RD_TRACK_MISS_CNT_EN
        chk("t4_miss", 32'(miss_cnt), 32'd1);
`endif
        set_r(1'b1, 1'b1);
        tick();
        set_r(1'b0, 1'b0);

        // Simultaneous push/pop, then reset mid-operation
        set_ar(32'h0000_1000, 1'b1, 1'b1);
        tick();
        set_ar(32'h0000_1004, 1'b1, 1'b1);
        tick();
        set_ar(32'h0000_1008, 1'b1, 1'b1);
        set_r(1'b1, 1'b1);
        tick();
        set_ar(32'h0, 1'b0, 1'b0);
        set_r(1'b0, 1'b0);
        @(negedge aclk);
        chk("t5_out_same", 32'(bus.outstanding), 32'd2);
        chk("t5_r_sel",    32'(bus.r_sel), 32'b0010);
        set_ar(32'h0000_100C, 1'b1, 1'b1);
        tick();
        set_ar(32'h0, 1'b0, 1'b0);
        @(negedge aclk);
        chk("t5_out_3", 32'(bus.outstanding), 32'd3);
        aresetn = 1'b0;
        tick();
        @(negedge aclk);
        chk("t5_rst_out",   32'(bus.outstanding), 32'd0);
        chk("t5_rst_r_sel", 32'(bus.r_sel), 32'd0);
        chk("t5_rst_block", 32'(bus.ar_block), 32'd0);
`ifdef AXIL_RD_TRACK_MISS_CNT_EN
        chk("t5_rst_miss", 32'(miss_cnt), 32'd0);
`endif
        tick();
        aresetn = 1'b1;
        tick();

        // Randomized traffic; the bench acts as a well-behaved interconnect
        for (int c = 0; c < 2000; c++) begin
            aresetn = ($urandom_range(0, 599) != 0);
            a = rand_addr();
            bus.m_araddr  = a;
            bus.m_arvalid = $urandom_range(0, 1);
            bus.m_arready = !ref_block(a) && ($urandom_range(0, 3) != 0);
            bus.m_rvalid  = $urandom_range(0, 1);
            bus.m_rready  = ($urandom_range(0, 2) != 0);
            tick();
        end
        aresetn = 1'b1;
        set_ar(32'h0, 1'b0, 1'b0);
        set_r(1'b0, 1'b0);
        tick();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
